// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter and access sequencer for the CPU data memory.
// Define ARB_ROUND_ROBIN_EN to break simultaneous requests by last owner instead of fixed A priority.
module data_mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              A_Req,
    input  logic              A_We,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_Wdata,
    output logic [DATA_W-1:0] A_Rdata,
    output logic              A_Done,
    input  logic              B_Req,
    input  logic              B_We,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_Wdata,
    output logic [DATA_W-1:0] B_Rdata,
    output logic              B_Done,
    output logic              Mem_En,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Data_in,
    input  logic [DATA_W-1:0] Mem_Data_out,
    output logic              Busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nxt;
    logic grant, pick_b, owner_b, we;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_b;
    assign pick_b = B_Req & (~A_Req | ~last_b);
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            last_b <= 1'b1;
        else if (grant)
            last_b <= pick_b;
    end
`else
    assign pick_b = ~A_Req;
`endif
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        grant = 1'b0;
        unique case (state)
            IDLE: begin
                grant = A_Req | B_Req;
                state_nxt = grant ? ACCESS : IDLE;
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // Gating with Reset_n keeps a reset landing on the ACCESS edge from committing the write.
    assign Mem_En = (state == ACCESS) & we & Reset_n;
    assign A_Done = (state == DONE) & ~owner_b;
    assign B_Done = (state == DONE) & owner_b;
    assign Busy   = state != IDLE;
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            owner_b     <= 1'b0;
            we          <= 1'b0;
            Mem_Address <= '0;
            Mem_Data_in <= '0;
            A_Rdata     <= '0;
            B_Rdata     <= '0;
        end else begin
            if (grant) begin
                owner_b     <= pick_b;
                we          <= pick_b ? B_We : A_We;
                Mem_Address <= pick_b ? B_Addr : A_Addr;
                Mem_Data_in <= pick_b ? B_Wdata : A_Wdata;
            end
            if (state == ACCESS && !we) begin
                if (owner_b)
                    B_Rdata <= Mem_Data_out;
                else
                    A_Rdata <= Mem_Data_out;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized self-checking bench against a transaction-level model of the arbiter.
module tb_data_mem_arbiter;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       A_Req, A_We, A_Done, B_Req, B_We, B_Done, Mem_En, Busy;
    logic [4:0] A_Addr, B_Addr, Mem_Address;
    logic [7:0] A_Wdata, A_Rdata, B_Wdata, B_Rdata, Mem_Data_in, Mem_Data_out;

    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];
    logic [7:0] exp_ra, exp_rb;
    bit         last_owner;
    int         checks = 0, failures = 0;
    int         a_cyc, b_cyc, a_cnt, b_cnt, en_cnt;
    bit         en_consec;
    logic [4:0] en_addr;
    logic [7:0] en_data;

    data_mem_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .A_Req(A_Req), .A_We(A_We), .A_Addr(A_Addr), .A_Wdata(A_Wdata), .A_Rdata(A_Rdata), .A_Done(A_Done),
        .B_Req(B_Req), .B_We(B_We), .B_Addr(B_Addr), .B_Wdata(B_Wdata), .B_Rdata(B_Rdata), .B_Done(B_Done),
        .Mem_En(Mem_En), .Mem_Address(Mem_Address), .Mem_Data_in(Mem_Data_in), .Mem_Data_out(Mem_Data_out),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;
    assign Mem_Data_out = mem[Mem_Address];
    always @(posedge Clk) if (Mem_En) mem[Mem_Address] <= Mem_Data_in;

    // Transaction-level prediction: serve order by arbitration rule, Done at 2 + 3*slot cycles.
    task automatic model_pair(input bit ra, input bit wa, input logic [4:0] aa, input logic [7:0] da,
                              input bit rb, input bit wb, input logic [4:0] ab, input logic [7:0] db,
                              output int ea, output int eb);
        bit b_first, pb;
        int k;
        k = 0; ea = 0; eb = 0;
`ifdef ARB_ROUND_ROBIN_EN
        b_first = rb && (!ra || last_owner == 1'b0);
`else
        b_first = rb && !ra;
`endif
        for (int s = 0; s < 2; s++) begin
            pb = (s == 0) ? b_first : !b_first;
            if (pb ? rb : ra) begin
                if (pb) eb = 2 + 3 * k; else ea = 2 + 3 * k;
                k++;
                last_owner = pb;
                if (pb ? wb : wa) ref_mem[pb ? ab : aa] = pb ? db : da;
                else if (pb) exp_rb = ref_mem[ab];
                else exp_ra = ref_mem[aa];
            end
        end
    endtask

    task automatic run_pair(input bit ra, input bit wa, input logic [4:0] aa, input logic [7:0] da,
                            input bit rb, input bit wb, input logic [4:0] ab, input logic [7:0] db);
        bit prev_en;
        prev_en = 0; a_cyc = 0; b_cyc = 0; a_cnt = 0; b_cnt = 0; en_cnt = 0; en_consec = 0;
        A_Req = ra; A_We = wa; A_Addr = aa; A_Wdata = da;
        B_Req = rb; B_We = wb; B_Addr = ab; B_Wdata = db;
        for (int c = 1; c <= 13; c++) begin
            @(posedge Clk); #1;
            if (Mem_En) begin
                if (prev_en) en_consec = 1;
                if (en_cnt == 0) begin en_addr = Mem_Address; en_data = Mem_Data_in; end
                en_cnt++;
            end
            prev_en = Mem_En;
            if (A_Done) begin a_cnt++; if (a_cyc == 0) a_cyc = c; A_Req = 0; end
            if (B_Done) begin b_cnt++; if (b_cyc == 0) b_cyc = c; B_Req = 0; end
            if (c == 13 || ((!ra || a_cnt > 0) && (!rb || b_cnt > 0))) begin
                @(posedge Clk); #1;
                if (A_Done) a_cnt++;
                if (B_Done) b_cnt++;
                if (Mem_En) en_cnt++;
                break;
            end
        end
        A_Req = 0; B_Req = 0;
    endtask

    task automatic test_reset;
        Reset_n = 0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if ({Mem_En, Mem_Address, Mem_Data_in} !== 14'd0) begin failures++; $display("FAIL reset_mem got=%0h exp=0", {Mem_En, Mem_Address, Mem_Data_in}); end
        checks++; if ({A_Rdata, B_Rdata} !== 16'd0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", {A_Rdata, B_Rdata}); end
        checks++; if ({A_Done, B_Done, Busy} !== 3'd0) begin failures++; $display("FAIL reset_flags got=%0b exp=0", {A_Done, B_Done, Busy}); end
        Reset_n = 1;
        last_owner = 1; exp_ra = 0; exp_rb = 0;
    endtask

    task automatic test_write_a;
        int ea, eb;
        model_pair(1, 1, 5'd5, 8'h3C, 0, 0, 5'd0, 8'h00, ea, eb);
        run_pair(1, 1, 5'd5, 8'h3C, 0, 0, 5'd0, 8'h00);
        checks++; if (a_cyc !== ea) begin failures++; $display("FAIL wr_a_latency got=%0d exp=%0d", a_cyc, ea); end
        checks++; if (en_cnt !== 1 || en_consec) begin failures++; $display("FAIL wr_a_en_count got=%0d exp=1", en_cnt); end
        checks++; if (en_addr !== 5'd5 || en_data !== 8'h3C) begin failures++; $display("FAIL wr_a_mem got=%0h/%0h exp=5/3c", en_addr, en_data); end
        checks++; if (b_cnt !== 0 || a_cnt !== 1) begin failures++; $display("FAIL wr_a_done_count got=%0d/%0d exp=1/0", a_cnt, b_cnt); end
    endtask

    task automatic test_read_b;
        int ea, eb;
        model_pair(0, 0, 5'd0, 8'h00, 1, 0, 5'd5, 8'h00, ea, eb);
        run_pair(0, 0, 5'd0, 8'h00, 1, 0, 5'd5, 8'h00);
        checks++; if (b_cyc !== eb || a_cnt !== 0) begin failures++; $display("FAIL rd_b_latency got=%0d/%0d exp=%0d/0", b_cyc, a_cnt, eb); end
        checks++; if (B_Rdata !== 8'h3C || B_Rdata !== exp_rb) begin failures++; $display("FAIL rd_b_data got=%0h exp=3c", B_Rdata); end
        checks++; if (A_Rdata !== 8'h00) begin failures++; $display("FAIL rd_b_a_rdata got=%0h exp=0", A_Rdata); end
        checks++; if (en_cnt !== 0) begin failures++; $display("FAIL rd_b_no_write got=%0d exp=0", en_cnt); end
    endtask

    task automatic test_simultaneous;
        int ea, eb;
        model_pair(1, 1, 5'd1, 8'h11, 1, 1, 5'd2, 8'h22, ea, eb);
        run_pair(1, 1, 5'd1, 8'h11, 1, 1, 5'd2, 8'h22);
        checks++; if (a_cyc !== ea || b_cyc !== eb) begin failures++; $display("FAIL tie_order got=%0d/%0d exp=%0d/%0d", a_cyc, b_cyc, ea, eb); end
        checks++; if (en_cnt !== 2 || en_consec) begin failures++; $display("FAIL tie_en got=%0d exp=2", en_cnt); end
        model_pair(1, 0, 5'd1, 8'h00, 1, 0, 5'd2, 8'h00, ea, eb);
        run_pair(1, 0, 5'd1, 8'h00, 1, 0, 5'd2, 8'h00);
        checks++; if (A_Rdata !== 8'h11 || B_Rdata !== 8'h22) begin failures++; $display("FAIL tie_readback got=%0h/%0h exp=11/22", A_Rdata, B_Rdata); end
    endtask

    task automatic test_contention;
        int owners [4];
        int cycs [4];
        int n, exp_owner;
        Reset_n = 0; @(posedge Clk); #1; Reset_n = 1;
        last_owner = 1; exp_ra = 0; exp_rb = 0;
        n = 0;
        A_Req = 1; A_We = 1; A_Addr = 5'd1; A_Wdata = 8'h11;
        B_Req = 1; B_We = 1; B_Addr = 5'd2; B_Wdata = 8'h22;
        for (int c = 1; c <= 20 && n < 4; c++) begin
            @(posedge Clk); #1;
            if (A_Done && n < 4) begin owners[n] = 0; cycs[n] = c; n++; end
            if (B_Done && n < 4) begin owners[n] = 1; cycs[n] = c; n++; end
        end
        A_Req = 0; B_Req = 0;
        checks++; if (n !== 4) begin failures++; $display("FAIL contention_count got=%0d exp=4", n); end
        for (int k = 0; k < n; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_owner = last_owner ? 0 : 1;
`else
            exp_owner = 0;
`endif
            last_owner = exp_owner[0];
            checks++; if (owners[k] !== exp_owner || cycs[k] !== 2 + 3 * k) begin failures++; $display("FAIL contention_slot%0d got=%0d@%0d exp=%0d@%0d", k, owners[k], cycs[k], exp_owner, 2 + 3 * k); end
        end
        ref_mem[1] = 8'h11; ref_mem[2] = 8'h22;
        @(posedge Clk); #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL contention_idle got=%0b exp=0", Busy); end
    endtask

    task automatic test_reset_abort;
        int ea, eb;
        model_pair(1, 1, 5'd7, 8'h5A, 0, 0, 5'd0, 8'h00, ea, eb);
        run_pair(1, 1, 5'd7, 8'h5A, 0, 0, 5'd0, 8'h00);
        A_Req = 1; A_We = 1; A_Addr = 5'd7; A_Wdata = 8'hFF;
        @(posedge Clk); #1;
        checks++; if (Mem_En !== 1'b1) begin failures++; $display("FAIL abort_access got=%0b exp=1", Mem_En); end
        Reset_n = 0;
        @(posedge Clk); #1;
        checks++; if (Busy !== 1'b0 || A_Done !== 1'b0) begin failures++; $display("FAIL abort_state got=%0b/%0b exp=0/0", Busy, A_Done); end
        A_Req = 0; Reset_n = 1;
        last_owner = 1; exp_ra = 0; exp_rb = 0;
        @(posedge Clk); #1;
        checks++; if (A_Done !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%0b/%0b exp=0/0", A_Done, Busy); end
        model_pair(1, 0, 5'd7, 8'h00, 0, 0, 5'd0, 8'h00, ea, eb);
        run_pair(1, 0, 5'd7, 8'h00, 0, 0, 5'd0, 8'h00);
        checks++; if (A_Rdata !== 8'h5A) begin failures++; $display("FAIL abort_readback got=%0h exp=5a", A_Rdata); end
    endtask

    task automatic test_addr_change;
        int ea, eb;
        model_pair(1, 1, 5'd3, 8'h33, 1, 1, 5'd9, 8'h99, ea, eb);
        run_pair(1, 1, 5'd3, 8'h33, 1, 1, 5'd9, 8'h99);
        A_Req = 1; A_We = 0; A_Addr = 5'd3;
        @(posedge Clk); #1;
        checks++; if (Mem_Address !== 5'd3) begin failures++; $display("FAIL addr_hold_access got=%0d exp=3", Mem_Address); end
        A_Addr = 5'd9;
        @(posedge Clk); #1;
        checks++; if (A_Done !== 1'b1 || A_Rdata !== ref_mem[3]) begin failures++; $display("FAIL addr_hold_data got=%0b/%0h exp=1/%0h", A_Done, A_Rdata, ref_mem[3]); end
        A_Req = 0;
        exp_ra = ref_mem[3]; last_owner = 0;
        @(posedge Clk); #1;
    endtask

    task automatic test_random;
        int ea, eb;
        bit ra, rb, wa, wb;
        logic [4:0] aa, ab;
        logic [7:0] da, db;
        for (int i = 0; i < 40; i++) begin
            ra = 1'($urandom); rb = 1'($urandom);
            if (!ra && !rb) ra = 1;
            wa = 1'($urandom); wb = 1'($urandom);
            aa = 5'($urandom); ab = 5'($urandom);
            da = 8'($urandom); db = 8'($urandom);
            model_pair(ra, wa, aa, da, rb, wb, ab, db, ea, eb);
            run_pair(ra, wa, aa, da, rb, wb, ab, db);
            checks++; if (a_cyc !== ea || b_cyc !== eb || a_cnt !== int'(ra) || b_cnt !== int'(rb)) begin failures++; $display("FAIL rand%0d_done got=%0d/%0d n=%0d/%0d exp=%0d/%0d", i, a_cyc, b_cyc, a_cnt, b_cnt, ea, eb); end
            checks++; if (en_cnt !== int'(ra && wa) + int'(rb && wb) || en_consec) begin failures++; $display("FAIL rand%0d_en got=%0d exp=%0d", i, en_cnt, int'(ra && wa) + int'(rb && wb)); end
            checks++; if (A_Rdata !== exp_ra || B_Rdata !== exp_rb) begin failures++; $display("FAIL rand%0d_rdata got=%0h/%0h exp=%0h/%0h", i, A_Rdata, B_Rdata, exp_ra, exp_rb); end
        end
        for (int j = 0; j < 32; j++) begin
            checks++; if (mem[j] !== ref_mem[j]) begin failures++; $display("FAIL mem_final[%0d] got=%0h exp=%0h", j, mem[j], ref_mem[j]); end
        end
    endtask

    initial begin
        A_Req = 0; A_We = 0; A_Addr = 0; A_Wdata = 0;
        B_Req = 0; B_We = 0; B_Addr = 0; B_Wdata = 0;
        Reset_n = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset;
        test_write_a;
        test_read_b;
        test_simultaneous;
        test_contention;
        test_reset_abort;
        test_addr_change;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
